// File: rtl/trg_pls_pkg.sv
// rtl/trg_pls_pkg.sv - opcodes, channel states and SPI frame layout for spi_trg_pls_gen
package trg_pls_pkg;

    localparam int FRAME_BITS = 24;
    localparam int OP_MSB     = 23;
    localparam int OP_LSB     = 21;
    localparam int CH_MSB     = 20;
    localparam int CH_LSB     = 16;
    localparam int DATA_MSB   = 15;
    localparam int DATA_LSB   = 0;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_WR_DELAY  = 3'd1,
        OP_WR_WIDTH  = 3'd2,
        OP_FIRE      = 3'd3,
        OP_ABORT     = 3'd4,
        OP_WR_PERIOD = 3'd5,
        OP_RSV6      = 3'd6,
        OP_RSV7      = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_GAP   = 2'd3
    } ch_state_e;

endpackage

// File: rtl/trg_pls_ch.sv
// rtl/trg_pls_ch.sv - one trigger channel FSM with delay/width/period counters
// Optional repeat mode (GAP state) is built when TRG_REPEAT_EN is defined.
module trg_pls_ch
    import trg_pls_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire,
    input  logic             abort,
    input  logic [CNT_W-1:0] dly,
    input  logic [CNT_W-1:0] wid,
`ifdef TRG_REPEAT_EN
    input  logic [CNT_W-1:0] per,
`endif
    output logic             trg,
    output logic             busy
);

    ch_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] wid_lat, wid_nxt;
`ifdef TRG_REPEAT_EN
    logic [CNT_W-1:0] per_lat, per_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            wid_lat <= CNT_W'(1);
            trg     <= 1'b0;
`ifdef TRG_REPEAT_EN
            per_lat <= '0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wid_lat <= wid_nxt;
            trg     <= (state_nxt == ST_HIGH);
`ifdef TRG_REPEAT_EN
            per_lat <= per_nxt;
`endif
        end
    end

    // cnt holds the cycles remaining in the current state minus one
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wid_nxt   = wid_lat;
`ifdef TRG_REPEAT_EN
        per_nxt   = per_lat;
`endif
        case (state)
            ST_IDLE: begin
                if (fire) begin
                    wid_nxt = wid;
`ifdef TRG_REPEAT_EN
                    per_nxt = per;
`endif
                    if (dly != '0) begin
                        state_nxt = ST_DELAY;
                        cnt_nxt   = dly - CNT_W'(1);
                    end else if (wid != '0) begin
                        state_nxt = ST_HIGH;
                        cnt_nxt   = wid - CNT_W'(1);
                    end
                end
            end
            ST_DELAY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (wid_lat != '0) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = wid_lat - CNT_W'(1);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = ST_IDLE;
`ifdef TRG_REPEAT_EN
                    if (per_lat > wid_lat) begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = per_lat - wid_lat - CNT_W'(1);
                    end
`endif
                end
            end
            ST_GAP: begin
`ifdef TRG_REPEAT_EN
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = wid_lat - CNT_W'(1);
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: rtl/spi_trg_pls_gen.sv
// rtl/spi_trg_pls_gen.sv - SPI-controlled multi-channel trigger pulse generator
// Define TRG_REPEAT_EN to add the period register and repeating pulse trains.
module spi_trg_pls_gen
    import trg_pls_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK50M,
    input  logic              RESET,
    input  logic              SPI_CS,
    input  logic              SPI_CLK,
    input  logic              SPI_MOSI,
    output logic [NUM_CH-1:0] TRG_PLS,
    output logic [NUM_CH-1:0] BUSY,
    output logic              FRAME_ERR
);

    logic [1:0]            cs_sync, clk_sync, mosi_sync;
    logic                  cs_d, clk_d;
    logic                  cs_rise, cs_fall, sclk_rise;
    logic [FRAME_BITS-1:0] sreg, frame_q;
    logic [4:0]            bit_cnt;
    logic                  len_ok, op_ok, cmt;
    opcode_e               op_f;
    logic [4:0]            ch_f;
    logic [15:0]           data_f;

    // CS idles high so a frame already in progress at reset release sees a fresh falling edge
    always_ff @(posedge CLK50M) begin
        if (RESET) begin
            cs_sync   <= 2'b11;
            cs_d      <= 1'b1;
            clk_sync  <= 2'b00;
            clk_d     <= 1'b0;
            mosi_sync <= 2'b00;
        end else begin
            cs_sync   <= {cs_sync[0], SPI_CS};
            cs_d      <= cs_sync[1];
            clk_sync  <= {clk_sync[0], SPI_CLK};
            clk_d     <= clk_sync[1];
            mosi_sync <= {mosi_sync[0], SPI_MOSI};
        end
    end

    assign cs_rise   = cs_sync[1] & ~cs_d;
    assign cs_fall   = ~cs_sync[1] & cs_d;
    assign sclk_rise = clk_sync[1] & ~clk_d;

    always_ff @(posedge CLK50M) begin
        if (RESET) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (cs_fall) begin
            bit_cnt <= '0;
        end else if (sclk_rise && !cs_sync[1]) begin
            sreg <= {sreg[FRAME_BITS-2:0], mosi_sync[1]};
            if (bit_cnt != 5'h1f) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    assign len_ok = (bit_cnt == 5'(FRAME_BITS));
    assign op_ok  = (sreg[OP_MSB:OP_LSB] < 3'd6);

    always_ff @(posedge CLK50M) begin
        if (RESET) begin
            cmt       <= 1'b0;
            FRAME_ERR <= 1'b0;
            frame_q   <= '0;
        end else begin
            cmt       <= cs_rise & len_ok & op_ok;
            FRAME_ERR <= cs_rise & ~(len_ok & op_ok);
            if (cs_rise) begin
                frame_q <= sreg;
            end
        end
    end

    assign op_f   = opcode_e'(frame_q[OP_MSB:OP_LSB]);
    assign ch_f   = frame_q[CH_MSB:CH_LSB];
    assign data_f = frame_q[DATA_MSB:DATA_LSB];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] dly_r, wid_r;
        logic             wr_sel, mask_bit;

        assign wr_sel = cmt && (ch_f == 5'(g));

        // channels beyond the 16-bit data field cannot be selected by a mask
        if (g <= DATA_MSB) begin : g_mask
            assign mask_bit = data_f[g];
        end else begin : g_nomask
            assign mask_bit = 1'b0;
        end

        always_ff @(posedge CLK50M) begin
            if (RESET) begin
                dly_r <= '0;
                wid_r <= CNT_W'(1);
            end else begin
                if (wr_sel && op_f == OP_WR_DELAY) dly_r <= data_f[CNT_W-1:0];
                if (wr_sel && op_f == OP_WR_WIDTH) wid_r <= data_f[CNT_W-1:0];
            end
        end

`ifdef TRG_REPEAT_EN
        logic [CNT_W-1:0] per_r;

        always_ff @(posedge CLK50M) begin
            if (RESET) begin
                per_r <= '0;
            end else if (wr_sel && op_f == OP_WR_PERIOD) begin
                per_r <= data_f[CNT_W-1:0];
            end
        end
`endif

        trg_pls_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk  (CLK50M),
            .rst  (RESET),
            .fire (cmt && op_f == OP_FIRE && mask_bit),
            .abort(cmt && op_f == OP_ABORT && mask_bit),
            .dly  (dly_r),
            .wid  (wid_r),
`ifdef TRG_REPEAT_EN
            .per  (per_r),
`endif
            .trg  (TRG_PLS[g]),
            .busy (BUSY[g])
        );
    end

endmodule

// File: tb/tb_spi_trg_pls_gen.sv
// tb/tb_spi_trg_pls_gen.sv - self-checking bench for spi_trg_pls_gen
module tb_spi_trg_pls_gen;

    localparam int NCH = 5;
`ifdef TRG_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic [NCH-1:0] trg, busy;
    logic ferr;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int m_dly[NCH], m_wid[NCH], m_per[NCH];
    int m_fc[NCH], m_d[NCH], m_w[NCH], m_p[NCH], m_ab[NCH];
    bit m_act[NCH];
    int m_err_cyc = -100;

    spi_trg_pls_gen #(.NUM_CH(NCH), .CNT_W(16)) dut (
        .CLK50M   (clk),
        .RESET    (rst),
        .SPI_CS   (cs),
        .SPI_CLK  (sclk),
        .SPI_MOSI (mosi),
        .TRG_PLS  (trg),
        .BUSY     (busy),
        .FRAME_ERR(ferr)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_dly[i] = 0; m_wid[i] = 1; m_per[i] = 0;
            m_act[i] = 0; m_ab[i] = -1;
        end
        m_err_cyc = -100;
    endfunction

    function automatic bit exp_trg(int i, int t);
        int s;
        if (!m_act[i] || t <= m_fc[i] || (m_ab[i] >= 0 && t > m_ab[i]) || m_w[i] == 0) return 1'b0;
        s = m_fc[i] + 1 + m_d[i];
        if (t < s) return 1'b0;
        if (REP && m_p[i] > m_w[i]) return ((t - s) % m_p[i]) < m_w[i];
        return t < s + m_w[i];
    endfunction

    function automatic bit exp_busy(int i, int t);
        if (!m_act[i] || t <= m_fc[i] || (m_ab[i] >= 0 && t > m_ab[i])) return 1'b0;
        if (REP && m_p[i] > m_w[i] && m_w[i] > 0) return 1'b1;
        return t <= m_fc[i] + m_d[i] + m_w[i];
    endfunction

    function automatic logic [NCH-1:0] exp_trg_vec(int t);
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = exp_trg(i, t);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_busy_vec(int t);
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = exp_busy(i, t);
        return v;
    endfunction

    // frame committed at cycle c takes effect from the channels' point of view in cycle c
    function automatic void model_commit(logic [31:0] f, int n, int c);
        int op, ch;
        logic [15:0] data;
        op = int'(f[23:21]);
        ch = int'(f[20:16]);
        data = f[15:0];
        if (n != 24 || op >= 6) begin
            m_err_cyc = c;
            return;
        end
        case (op)
            1: if (ch < NCH) m_dly[ch] = int'(data);
            2: if (ch < NCH) m_wid[ch] = int'(data);
            3: for (int i = 0; i < NCH; i++)
                   if (data[i] && !exp_busy(i, c)) begin
                       m_act[i] = 1; m_fc[i] = c; m_ab[i] = -1;
                       m_d[i] = m_dly[i]; m_w[i] = m_wid[i]; m_p[i] = m_per[i];
                   end
            4: for (int i = 0; i < NCH; i++)
                   if (data[i] && m_act[i] && m_ab[i] < 0) m_ab[i] = c;
            5: if (REP && ch < NCH) m_per[ch] = int'(data);
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] mk(int op, int ch, int data);
        return {8'h00, 3'(op), 5'(ch), 16'(data)};
    endfunction

    task automatic spi_bits(input logic [31:0] f, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = f[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] f, input int n, output int c);
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(f, n);
        repeat (4) @(negedge clk);
        cs = 1'b1;
        c = cyc + 3;
        model_commit(f, n, c);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (trg !== '0 || busy !== '0 || ferr !== 1'b0) begin
            errors++;
            $display("FAIL reset trg=%b busy=%b err=%b required all zero", trg, busy, ferr);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_defaults();
        int c;
        send_frame(mk(3, 0, 16'h001F), 24, c);
        for (int t = c - 1; t <= c + 6; t++) begin
            while (cyc < t) @(negedge clk);
            checks++;
            if (trg !== exp_trg_vec(t) || busy !== exp_busy_vec(t) || ferr !== (t == m_err_cyc)) begin
                errors++;
                $display("FAIL defaults t=%0d trg=%b/%b busy=%b/%b err=%b/%b", t, trg, exp_trg_vec(t),
                         busy, exp_busy_vec(t), ferr, t == m_err_cyc);
            end
        end
    endtask

    task automatic test_basic();
        int c;
        send_frame(mk(1, 2, 10), 24, c);
        send_frame(mk(2, 2, 4), 24, c);
        send_frame(mk(3, 0, 16'h0004), 24, c);
        for (int t = c - 1; t <= c + 20; t++) begin
            while (cyc < t) @(negedge clk);
            checks++;
            if (trg !== exp_trg_vec(t) || busy !== exp_busy_vec(t) || ferr !== (t == m_err_cyc)) begin
                errors++;
                $display("FAIL basic t=%0d trg=%b/%b busy=%b/%b err=%b/%b", t, trg, exp_trg_vec(t),
                         busy, exp_busy_vec(t), ferr, t == m_err_cyc);
            end
        end
    endtask

    task automatic test_frame_err();
        int c;
        logic [31:0] fr [3];
        int nb [3];
        fr[0] = mk(3, 0, 16'h001F);                nb[0] = 23;
        fr[1] = mk(3, 0, 16'h001F) | 32'h0100_0000; nb[1] = 25;
        fr[2] = mk(7, 0, 16'h001F);                nb[2] = 24;
        for (int k = 0; k < 3; k++) begin
            send_frame(fr[k], nb[k], c);
            for (int t = c - 1; t <= c + 8; t++) begin
                while (cyc < t) @(negedge clk);
                checks++;
                if (trg !== exp_trg_vec(t) || busy !== exp_busy_vec(t) || ferr !== (t == m_err_cyc)) begin
                    errors++;
                    $display("FAIL frame_err k=%0d t=%0d trg=%b/%b busy=%b/%b err=%b/%b", k, t, trg,
                             exp_trg_vec(t), busy, exp_busy_vec(t), ferr, t == m_err_cyc);
                end
            end
        end
    endtask

    task automatic test_random();
        int c;
        for (int it = 0; it < 4; it++) begin
            send_frame(mk(1, $urandom_range(0, 7), $urandom_range(0, 12)), 24, c);
            send_frame(mk(2, $urandom_range(0, 7), $urandom_range(0, 10)), 24, c);
            send_frame(mk(3, 0, $urandom_range(1, 16'hFFFF)), 24, c);
            for (int t = c - 1; t <= c + 28; t++) begin
                while (cyc < t) @(negedge clk);
                checks++;
                if (trg !== exp_trg_vec(t) || busy !== exp_busy_vec(t) || ferr !== (t == m_err_cyc)) begin
                    errors++;
                    $display("FAIL random it=%0d t=%0d trg=%b/%b busy=%b/%b err=%b/%b", it, t, trg,
                             exp_trg_vec(t), busy, exp_busy_vec(t), ferr, t == m_err_cyc);
                end
            end
        end
    endtask

    task automatic test_abort();
        int c;
        logic [31:0] fr [5];
        fr[0] = mk(2, 0, 1500);
        fr[1] = mk(1, 0, 0);
        fr[2] = mk(3, 0, 16'h0001);
        fr[3] = mk(1, 0, 20);
        fr[4] = mk(3, 0, 16'h0001);
        for (int k = 0; k < 5; k++) send_frame(fr[k], 24, c);
        for (int pass = 0; pass < 2; pass++) begin
            for (int t = c - 1; t <= c + 25; t++) begin
                while (cyc < t) @(negedge clk);
                checks++;
                if (trg !== exp_trg_vec(t) || busy !== exp_busy_vec(t) || ferr !== (t == m_err_cyc)) begin
                    errors++;
                    $display("FAIL abort pass=%0d t=%0d trg=%b/%b busy=%b/%b err=%b/%b", pass, t, trg,
                             exp_trg_vec(t), busy, exp_busy_vec(t), ferr, t == m_err_cyc);
                end
            end
            if (pass == 0) send_frame(mk(4, 0, 16'h0001), 24, c);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        send_frame(mk(2, 3, 2000), 24, c);
        send_frame(mk(3, 0, 16'h0008), 24, c);
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(32'h0000_03A5, 10);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (trg !== '0 || busy !== '0 || ferr !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid trg=%b busy=%b err=%b required all zero", trg, busy, ferr);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        spi_bits(32'h0000_001F, 14);
        repeat (4) @(negedge clk);
        cs = 1'b1;
        c = cyc + 3;
        m_err_cyc = c;
        for (int pass = 0; pass < 2; pass++) begin
            for (int t = c - 1; t <= c + 6; t++) begin
                while (cyc < t) @(negedge clk);
                checks++;
                if (trg !== exp_trg_vec(t) || busy !== exp_busy_vec(t) || ferr !== (t == m_err_cyc)) begin
                    errors++;
                    $display("FAIL reset_mid pass=%0d t=%0d trg=%b/%b busy=%b/%b err=%b/%b", pass, t, trg,
                             exp_trg_vec(t), busy, exp_busy_vec(t), ferr, t == m_err_cyc);
                end
            end
            if (pass == 0) send_frame(mk(3, 0, 16'h0008), 24, c);
        end
    endtask

    task automatic test_repeat();
        int c;
        send_frame(mk(1, 1, 2), 24, c);
        send_frame(mk(2, 1, 3), 24, c);
        send_frame(mk(5, 1, 8), 24, c);
        send_frame(mk(3, 0, 16'h0002), 24, c);
        for (int pass = 0; pass < 2; pass++) begin
            for (int t = c - 1; t <= c + 40; t++) begin
                while (cyc < t) @(negedge clk);
                checks++;
                if (trg !== exp_trg_vec(t) || busy !== exp_busy_vec(t) || ferr !== (t == m_err_cyc)) begin
                    errors++;
                    $display("FAIL repeat pass=%0d t=%0d trg=%b/%b busy=%b/%b err=%b/%b", pass, t, trg,
                             exp_trg_vec(t), busy, exp_busy_vec(t), ferr, t == m_err_cyc);
                end
            end
            if (pass == 0) send_frame(mk(4, 0, 16'h0002), 24, c);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_defaults();
        test_basic();
        test_frame_err();
        test_random();
        test_abort();
        test_reset_mid();
        test_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
